// File: rtl/iopad_bank_ctrl_pkg.sv
// Shared constants and types for the IO pad bank controller:
// default bank geometry, pad-cell reset levels and the filter action encoding.
package iopad_bank_ctrl_pkg;

  localparam int unsigned NUM_CH_DEFAULT      = 8;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned FILT_W_DEFAULT      = 4;

  // Pad-cell control levels while in reset: output low, tri-stated, pull enabled.
  localparam logic RST_I   = 1'b0;
  localparam logic RST_OEN = 1'b1;
  localparam logic RST_REN = 1'b0;

  // What the glitch filter does on a given clock edge.
  typedef enum logic [1:0] {
    FILT_HOLD  = 2'd0,  // synchronised input agrees with din: clear the counter
    FILT_COUNT = 2'd1,  // disagreement not yet stable long enough: keep counting
    FILT_TAKE  = 2'd2   // disagreement stable for T_eff cycles: adopt new value
  } filt_act_e;

endpackage

// File: rtl/iopad_bank_ctrl_in_filter.sv
// One pad input channel: multi-flop synchroniser, programmable glitch filter
// and registered rise/fall edge pulses.
module iopad_bank_ctrl_in_filter
  import iopad_bank_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned FILT_W      = FILT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad_c_i,
  input  logic              filt_en_i,
  input  logic [FILT_W-1:0] filt_thresh_i,
  output logic              din_o,
  output logic              rise_o,
  output logic              fall_o
);

  localparam logic [FILT_W:0] ONE = (FILT_W + 1)'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   din_q, din_d;
  logic                   din_dly_q;
  logic                   rise_q, fall_q;
  logic [FILT_W:0]        t_eff;
  logic [FILT_W:0]        cnt_inc;
  filt_act_e              act;

  // Shift the asynchronous pad value through the synchroniser chain.
  // NOTE: every flop here, synchroniser included, takes the async reset so the
  // filter never starts from an unknown level after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_c_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Effective stable-cycle threshold: 1 when the filter is off or programmed to 0.
  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    t_eff = ONE;
    if (filt_en_i && (filt_thresh_i != '0)) begin
      t_eff = {1'b0, filt_thresh_i};
    end
  end

  // Compare in FILT_W+1 bits; COUNT only happens while cnt+1 < t_eff, so no wrap.
  assign cnt_inc = {1'b0, cnt_q} + ONE;

  // Choose the filter action and form the next counter / din values.
  always_comb begin
    act   = FILT_COUNT;
    cnt_d = cnt_inc[FILT_W-1:0];
    din_d = din_q;
    if (s == din_q) begin
      act = FILT_HOLD;
    end else if (cnt_inc >= t_eff) begin
      act = FILT_TAKE;
    end
    unique case (act)
      FILT_HOLD: cnt_d = '0;
      FILT_TAKE: begin
        cnt_d = '0;
        din_d = s;
      end
      default: ;
    endcase
  end

  // Filter state, delayed din and edge pulses one cycle after din changes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      din_q     <= 1'b0;
      din_dly_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      din_dly_q <= din_q;
      rise_q    <= din_q & ~din_dly_q;
      fall_q    <= ~din_q & din_dly_q;
    end
  end

  assign din_o  = din_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/iopad_bank_ctrl.sv
// Bank of NUM_CH bidirectional pads: registered drive/OE/pull controls toward
// the pad ring and a synchronised, glitch-filtered input path toward the core.
module iopad_bank_ctrl
  import iopad_bank_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned FILT_W      = FILT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] dout,
  input  logic [NUM_CH-1:0] oe,
  input  logic [NUM_CH-1:0] pull_en,
  input  logic [NUM_CH-1:0] filt_en,
  input  logic [FILT_W-1:0] filt_thresh,
  output logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  inout  wire  [NUM_CH-1:0] PAD
);

  logic [NUM_CH-1:0] pad_i_q;
  logic [NUM_CH-1:0] pad_oen_q;
  logic [NUM_CH-1:0] pad_ren_q;
  logic [NUM_CH-1:0] pad_c;
  logic              unused_ren;

  // Register the core-side controls so nothing combinational reaches the pads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_i_q   <= {NUM_CH{RST_I}};
      pad_oen_q <= {NUM_CH{RST_OEN}};
      pad_ren_q <= {NUM_CH{RST_REN}};
    end else begin
      pad_i_q   <= dout;
      pad_oen_q <= ~oe;
      pad_ren_q <= ~pull_en;
    end
  end

  // The pull resistor lives inside the analog cell; the behavioural pad model
  // below has no pull, so REN only terminates here.
  assign unused_ren = ^pad_ren_q;

  // Behavioural PDD pad cells; the DONT_TOUCH prefix keeps them preserved.
  for (genvar g = 0; g < NUM_CH; g++) begin : DONT_TOUCH_pad
    assign PAD[g]   = pad_oen_q[g] ? 1'bz : pad_i_q[g];
    assign pad_c[g] = PAD[g];
  end

  // Independent input channels sharing only the filter threshold.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_in
    iopad_bank_ctrl_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_in_filter (
      .clk           (clk),
      .rst_n         (rst_n),
      .pad_c_i       (pad_c[g]),
      .filt_en_i     (filt_en[g]),
      .filt_thresh_i (filt_thresh),
      .din_o         (din[g]),
      .rise_o        (rise[g]),
      .fall_o        (fall[g])
    );
  end

endmodule

// File: tb/tb_iopad_bank_ctrl.sv
// Directed bench for iopad_bank_ctrl (NUM_CH=8, SYNC_STAGES=2, FILT_W=4).
module tb_iopad_bank_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] dout, oe, pull_en, filt_en;
  logic [3:0] filt_thresh;
  logic [7:0] din, rise, fall;
  wire  [7:0] PAD;
  logic [7:0] tb_en, tb_val;

  int n_cmp = 0;
  int n_bad = 0;

  iopad_bank_ctrl #(
    .NUM_CH      (8),
    .SYNC_STAGES (2),
    .FILT_W      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dout        (dout),
    .oe          (oe),
    .pull_en     (pull_en),
    .filt_en     (filt_en),
    .filt_thresh (filt_thresh),
    .din         (din),
    .rise        (rise),
    .fall        (fall),
    .PAD         (PAD)
  );

  // External drivers on the pad ring, released per bit.
  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign PAD[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; dout = '0; oe = '0; pull_en = '0; filt_en = '0; filt_thresh = '0;
    tb_en = 8'hFF; tb_val = 8'h00;

    // Reset takes effect with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_oen",  32'(dut.pad_oen_q), 32'hFF);
    check("rst_ren",  32'(dut.pad_ren_q), 32'h00);
    check("rst_i",    32'(dut.pad_i_q),   32'h00);
    check("rst_din",  32'(din), 32'h00);
    check("rst_edge", 32'({rise, fall}), 32'h0);
    tb_val = 8'hFF;
    step(3);
    check("rst_hold_din", 32'(din), 32'h00);
    tb_val = 8'h00;
    rst_n  = 1'b1;
    step(4);
    check("post_rst_din", 32'(din), 32'h00);

    // Pull control is registered.
    pull_en = 8'hFF;
    check("ren_no_comb", 32'(dut.pad_ren_q), 32'hFF);
    step(1);
    check("ren_all_on", 32'(dut.pad_ren_q), 32'h00);
    pull_en = 8'h0F;
    step(1);
    check("ren_mixed", 32'(dut.pad_ren_q), 32'hF0);
    pull_en = 8'h00;

    // Output drive and loopback through the input path.
    oe = 8'hFF; dout = 8'hA5; tb_en = 8'h00;
    check("oen_no_comb", 32'(dut.pad_oen_q), 32'hFF);
    step(1);
    check("pad_drive_a5", 32'(PAD), 32'hA5);
    check("oen_driving",  32'(dut.pad_oen_q), 32'h00);
    step(2);
    check("loop_lat_early", 32'(din), 32'h00);
    step(1);
    check("loop_din_a5", 32'(din), 32'hA5);
    step(1);
    check("loop_edge_a5", 32'({rise, fall}), 32'hA500);
    dout = 8'h5A;
    step(1);
    check("pad_drive_5a", 32'(PAD), 32'h5A);
    step(3);
    check("loop_din_5a", 32'(din), 32'h5A);
    step(1);
    check("loop_edge_5a", 32'({rise, fall}), 32'h5AA5);

    // Release the pads back to the external driver.
    oe = 8'h00; tb_val = 8'h5A; tb_en = 8'hFF;
    step(1);
    check("oen_released", 32'(dut.pad_oen_q), 32'hFF);
    tb_val = 8'h0F;
    #1;
    check("pad_hiz_follow", 32'(PAD), 32'h0F);
    tb_val = 8'h00;
    step(8);
    check("settle_din", 32'(din), 32'h00);

    // Filter off: din follows after SYNC_STAGES+1 edges, one rise pulse.
    tb_val = 8'h01;
    step(2);
    check("nofilt_early", 32'(din), 32'h00);
    step(1);
    check("nofilt_din", 32'(din), 32'h01);
    step(1);
    check("nofilt_rise", 32'(rise), 32'h01);
    step(1);
    check("nofilt_rise_end", 32'(rise), 32'h00);
    tb_val = 8'h00;
    step(3);
    check("nofilt_din_low", 32'(din), 32'h00);
    step(1);
    check("nofilt_fall", 32'({rise, fall}), 32'h0001);

    // Threshold 4: a 3-cycle glitch is swallowed.
    filt_en = 8'hFF; filt_thresh = 4'd4;
    tb_val = 8'h02;
    step(3);
    tb_val = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch3_quiet", 32'({din, rise}), 32'h0);
    end

    // Threshold 4: a 4-cycle pulse passes, then decays after 4 low cycles.
    tb_val = 8'h02;
    step(4);
    tb_val = 8'h00;
    step(1);
    check("pulse4_early", 32'(din), 32'h00);
    step(1);
    check("pulse4_din", 32'(din), 32'h02);
    step(1);
    check("pulse4_rise", 32'(rise), 32'h02);
    step(2);
    check("pulse4_hold", 32'(din), 32'h02);
    step(1);
    check("pulse4_din_low", 32'(din), 32'h00);
    step(1);
    check("pulse4_fall", 32'({rise, fall}), 32'h0002);

    // Threshold 0 with filter on behaves as filter off.
    filt_thresh = 4'd0;
    tb_val = 8'h04;
    step(2);
    check("thr0_early", 32'(din), 32'h00);
    step(1);
    check("thr0_din", 32'(din), 32'h04);
    step(1);
    check("thr0_rise", 32'(rise), 32'h04);
    tb_val = 8'h00;
    step(6);
    check("thr0_settle", 32'(din), 32'h00);

    // Threshold 8 lowered to 2 with the counter at 5: update on the next edge.
    filt_thresh = 4'd8;
    tb_val = 8'h08;
    step(7);
    check("thr8_cnt5", 32'(din), 32'h00);
    filt_thresh = 4'd2;
    step(1);
    check("thr8to2_din", 32'(din), 32'h08);
    step(1);
    check("thr8to2_rise", 32'(rise), 32'h08);

    // Filter disabled mid-count (cnt=3, threshold 8): update on the next edge.
    filt_thresh = 4'd8;
    tb_val = 8'h18;
    step(5);
    check("fen_cnt3", 32'(din), 32'h08);
    filt_en = 8'h00;
    step(1);
    check("fen_off_din", 32'(din), 32'h18);

    // Reset mid-count, then re-acquire from scratch with pads held high.
    filt_en = 8'hFF; filt_thresh = 4'd4;
    tb_val = 8'h38;
    step(5);
    check("pre_rst_din", 32'(din), 32'h18);
    rst_n = 1'b0;
    #1;
    check("midrst_din",  32'(din), 32'h00);
    check("midrst_edge", 32'({rise, fall}), 32'h0);
    step(2);
    check("midrst_hold", 32'(din), 32'h00);
    rst_n = 1'b1;
    step(5);
    check("reacq_early", 32'(din), 32'h00);
    step(1);
    check("reacq_din", 32'(din), 32'h38);
    step(1);
    check("reacq_rise", 32'({rise, fall}), 32'h3800);
    step(1);
    check("reacq_rise_end", 32'(rise), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
